// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start / DATA_BITS / stop, LSB first, idle-high).
// The line is double-flopped into the clk domain. A start bit is qualified at its centre,
// and each data bit and the stop bit are sampled one full bit period apart.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]           sync_q;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: only oversample ticks advance anything; strobes self-clear every clk.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (tcnt_q == T_HALF) begin
                        if (rx_s) begin
                            // Line went back high before the start-bit centre: a glitch.
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tcnt_q == T_LAST) begin
                        // Shift in from the top so the first bit ends up in the LSB.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tcnt_d  = '0;
                        if (bcnt_q == B_LAST) begin
                            bcnt_d  = '0;
                            state_d = S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tcnt_q == T_LAST) begin
                        data_d = shift_q;
                        tcnt_d = '0;
                        if (rx_s) begin
                            // Leaving at the stop-bit centre lets a following start edge be seen.
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high so a held-low line reports only once.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and random frames driven bit-by-bit on the line,
// received words compared against the list of frames that were sent.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en, clk_en2;
    logic       rx;
    logic [7:0] rx_data, rx_data2;
    logic       rx_valid, rx_valid2;
    logic       frame_err, frame_err2;
    logic       busy, busy2;

    int errors = 0;
    int checks = 0;

    logic [7:0] got1[$];
    logic [7:0] got2[$];
    logic [7:0] exp_q[$];
    int         ferr1 = 0;
    logic [7:0] ferr_data = 8'h00;
    bit         both_seen = 1'b0;
    bit         busy_seen = 1'b0;

    always #10 clk = ~clk;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .clk_en(clk_en2), .rx(rx),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2), .busy(busy2)
    );

    // Tick generators: every 16 clk for the x16 receiver, every 32 clk for the x8 one.
    initial begin
        int tick_cnt;
        tick_cnt = 0;
        clk_en   = 1'b0;
        clk_en2  = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt = tick_cnt + 1;
            clk_en   = (tick_cnt % 16) == 0;
            clk_en2  = (tick_cnt % 32) == 0;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) got1.push_back(rx_data);
        if (rx_valid2) got2.push_back(rx_data2);
        if (frame_err) begin
            ferr1     <= ferr1 + 1;
            ferr_data <= rx_data;
        end
        if (rx_valid && frame_err) both_seen <= 1'b1;
        if (busy) busy_seen <= 1'b1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [7:0] v;
        v = b;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int         n0;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        wait_clks(100);

        // 1. Two ordinary frames.
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        wait_clks(300);
        check("t1_count", got1.size(), 2);
        if (got1.size() == 2) begin
            check("t1_byte0", got1[0], 8'h55);
            check("t1_byte1", got1[1], 8'hA3);
        end
        check("t1_ferr", ferr1, 0);

        // 2. Back-to-back frames with no idle gap.
        got1.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(300);
        check("t2_count", got1.size(), 2);
        if (got1.size() == 2) begin
            check("t2_byte0", got1[0], 8'h00);
            check("t2_byte1", got1[1], 8'hFF);
        end

        // 3. Short low glitch: 4 ticks low.
        got1.delete();
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_clks(64);
        rx = 1'b1;
        wait_clks(600);
        check("t3_busy_pulsed", busy_seen, 1);
        check("t3_busy_now", busy, 0);
        check("t3_no_valid", got1.size(), 0);
        check("t3_no_ferr", ferr1, 0);

        // 4. Framing error followed by a held-low line, then a good frame.
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        check("t4_ferr_once", ferr1, 1);
        check("t4_ferr_data", ferr_data, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            wait_clks(BIT_CLKS);
            check($sformatf("t4_busy_low%0d", i), busy, 1);
        end
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("t4_busy_idle", busy, 0);
        check("t4_ferr_still_once", ferr1, 1);
        check("t4_no_valid", got1.size(), 0);
        send_frame(8'h0F, 1'b1);
        wait_clks(300);
        check("t4_count", got1.size(), 1);
        if (got1.size() == 1) check("t4_byte", got1[0], 8'h0F);

        // 5. Reset during data bit 4 of 0xC6.
        got1.delete();
        b = 8'hC6;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rx = b[4];
        wait_clks(BIT_CLKS / 2);
        check("t5_busy_before", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_data", rx_data, 0);
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_ferr", frame_err, 0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("t5_no_strobe", got1.size(), 0);
        send_frame(8'h81, 1'b1);
        wait_clks(300);
        check("t5_count", got1.size(), 1);
        if (got1.size() == 1) check("t5_byte", got1[0], 8'h81);

        // Random frames with random idle gaps.
        got1.delete();
        exp_q.delete();
        n0 = ferr1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            wait_clks($urandom_range(0, 600));
        end
        wait_clks(300);
        check("rnd_count", got1.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got1.size(); i++)
            check($sformatf("rnd_byte%0d", i), got1[i], exp_q[i]);
        check("rnd_no_ferr", ferr1, n0);

        // 6. Oversample-by-8 receiver, tick every 32 clk.
        got2.delete();
        send_frame(8'h5A, 1'b1);
        wait_clks(300);
        check("t6_count", got2.size(), 1);
        if (got2.size() == 1) check("t6_byte", got2[0], 8'h5A);

        check("never_both_strobes", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
